// File: rtl/msrv32_store_unit.sv
// msrv32_store_unit: store path between the decoder and the AHB data port.
// Aligns SB/SH/SW data onto byte lanes, produces the word address and the
// byte-lane write mask, and registers everything with one cycle of latency.
// Captures happen only on edges where ahb_ready_in=1, so a bus wait state
// holds every output.
// Optional feature (macro STORE_MISALIGN_CHECK_EN): adds misaligned_store_out
// and suppresses the bus request for misaligned SH/SW stores.
module msrv32_store_unit (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [1:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        mem_wr_req_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]  ahb_htrans_out
`ifdef STORE_MISALIGN_CHECK_EN
  ,
  output logic        misaligned_store_out
`endif
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]  byte_off;
  logic [31:0] data_next;
  logic [3:0]  mask_next;
  logic        issue;
`ifdef STORE_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  assign byte_off = iadder_in[1:0];

  // Lane alignment of store data and byte-enable generation by access size.
  always_comb begin
    data_next = '0;
    mask_next = '0;
    case (funct3_in)
      2'b00: begin
        data_next = {24'h0, rs2_in[7:0]} << {byte_off, 3'b000};
        mask_next = 4'b0001 << byte_off;
      end
      2'b01: begin
        if (byte_off[1]) begin
          data_next = {rs2_in[15:0], 16'h0};
          mask_next = 4'b1100;
        end else begin
          data_next = {16'h0, rs2_in[15:0]};
          mask_next = 4'b0011;
        end
      end
      default: begin
        data_next = rs2_in;
        mask_next = 4'b1111;
      end
    endcase
  end

`ifdef STORE_MISALIGN_CHECK_EN
  // A halfword must be 2-byte aligned and a word 4-byte aligned.
  always_comb begin
    misaligned = 1'b0;
    case (funct3_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = byte_off[0];
      default: misaligned = |byte_off;
    endcase
  end

  assign issue = mem_wr_req_in & ~misaligned;
`else
  assign issue = mem_wr_req_in;
`endif

  // Output registers; reset wins over the bus ready, wait states hold.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      ms_riscv32_mp_dmdata_out    <= '0;
      ms_riscv32_mp_dmaddr_out    <= '0;
      ms_riscv32_mp_dmwr_mask_out <= '0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      ahb_htrans_out              <= HTRANS_IDLE;
`ifdef STORE_MISALIGN_CHECK_EN
      misaligned_store_out        <= 1'b0;
`endif
    end else if (ahb_ready_in) begin
      ms_riscv32_mp_dmdata_out    <= data_next;
      ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
      ms_riscv32_mp_dmwr_mask_out <= issue ? mask_next : 4'b0000;
      ms_riscv32_mp_dmwr_req_out  <= issue;
      ahb_htrans_out              <= issue ? HTRANS_NONSEQ : HTRANS_IDLE;
`ifdef STORE_MISALIGN_CHECK_EN
      misaligned_store_out        <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Testbench for msrv32_store_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the store rules.
module tb_msrv32_store_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  funct3;
  logic [31:0] iadder;
  logic [31:0] rs2;
  logic        ready;
  logic        req;
  logic [31:0] dmdata;
  logic [31:0] dmaddr;
  logic [3:0]  dmmask;
  logic        dmreq;
  logic [1:0]  htrans;
  logic        mis;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Bundle layout: [71:40] data, [39:8] addr, [7:4] mask, [3] req, [2:1] htrans, [0] misaligned
  logic [71:0] obs;
  logic [71:0] exp_b;

  msrv32_store_unit dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .funct3_in                   (funct3),
    .iadder_in                   (iadder),
    .rs2_in                      (rs2),
    .ahb_ready_in                (ready),
    .mem_wr_req_in               (req),
    .ms_riscv32_mp_dmdata_out    (dmdata),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmwr_mask_out (dmmask),
    .ms_riscv32_mp_dmwr_req_out  (dmreq),
    .ahb_htrans_out              (htrans)
`ifdef STORE_MISALIGN_CHECK_EN
    ,
    .misaligned_store_out        (mis)
`endif
  );

`ifndef STORE_MISALIGN_CHECK_EN
  assign mis = 1'b0;
`endif

  assign obs = {dmdata, dmaddr, dmmask, dmreq, htrans, mis};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the registered outputs become after one edge.
  function automatic logic [71:0] model_next(input logic [71:0] cur,
                                             input logic r, input logic rdy,
                                             input logic rq, input logic [1:0] f3,
                                             input logic [31:0] a, input logic [31:0] d);
    int unsigned off;
    longint unsigned data;
    int unsigned mask;
    logic misal;
    logic go;
    logic [31:0] data32;
    logic [3:0]  mask4;
    if (r) return '0;
    if (!rdy) return cur;
    off = a % 4;
    misal = 1'b0;
    if (f3 == 2'd0) begin
      data = longint'(d % 256) * (longint'(1) << (8 * off));
      mask = 1 << off;
    end else if (f3 == 2'd1) begin
      data = longint'(d % 65536) * ((off >= 2) ? 65536 : 1);
      mask = (off >= 2) ? 12 : 3;
      misal = (off % 2) != 0;
    end else begin
      data = d;
      mask = 15;
      misal = off != 0;
    end
`ifndef STORE_MISALIGN_CHECK_EN
    misal = 1'b0;
`endif
    go = rq && !misal;
    data32 = data[31:0];
    mask4 = go ? mask[3:0] : 4'd0;
    return {data32, a - off, mask4, go, go ? 2'b10 : 2'b00, misal};
  endfunction

  task automatic drive(input logic r, input logic rdy, input logic rq,
                       input logic [1:0] f3, input logic [31:0] a, input logic [31:0] d);
    rst = r; ready = rdy; req = rq; funct3 = f3; iadder = a; rs2 = d;
  endtask

  // One edge: model follows the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    exp_b = model_next(exp_b, rst, ready, req, funct3, iadder, rs2);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h1234_5678);
    tick();
    exp_b = '0;
    n_checks++;
    if (obs !== 72'h0)
      $display("FAIL reset_state: got %h expected %h", obs, 72'h0);
    else n_pass++;
  endtask

  task automatic test_directed();
    drive(1'b0, 1'b1, 1'b1, 2'b01, 32'h1234_5672, 32'hABCD_EF01);
    tick();
    n_checks++;
    if (obs !== {32'hEF01_0000, 32'h1234_5670, 4'b1100, 1'b1, 2'b10, 1'b0})
      $display("FAIL sh_upper: got %h expected data=EF010000 addr=12345670 mask=1100 req=1 htrans=10", obs);
    else n_pass++;

    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0103, 32'h0000_00A5);
    tick();
    n_checks++;
    if (obs !== {32'hA500_0000, 32'h0000_0100, 4'b1000, 1'b1, 2'b10, 1'b0})
      $display("FAIL sb_lane3: got %h expected data=A5000000 addr=00000100 mask=1000", obs);
    else n_pass++;

    drive(1'b0, 1'b1, 1'b1, 2'b11, 32'h0000_0040, 32'h0BAD_F00D);
    tick();
    n_checks++;
    if (obs !== {32'h0BAD_F00D, 32'h0000_0040, 4'b1111, 1'b1, 2'b10, 1'b0})
      $display("FAIL funct3_11_as_sw: got %h expected data=0BADF00D mask=1111", obs);
    else n_pass++;

    drive(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'h0000_BEEF);
    tick();
    n_checks++;
    if (obs !== {32'h0000_BEEF, 32'h0000_0010, 4'b0000, 1'b0, 2'b00, 1'b0})
      $display("FAIL no_request: got %h expected data=0000BEEF mask=0000 req=0 htrans=00", obs);
    else n_pass++;

`ifdef STORE_MISALIGN_CHECK_EN
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_0002, 32'h5555_AAAA);
    tick();
    n_checks++;
    if (obs[7:0] !== {4'b0000, 1'b0, 2'b00, 1'b1})
      $display("FAIL misaligned_sw: got mask/req/htrans/mis %b expected 0000_0_00_1", obs[7:0]);
    else n_pass++;
`endif
  endtask

  task automatic test_wait_state();
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h2000_0004, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, $urandom_range(0, 1), 2'($urandom), $urandom, $urandom);
      tick();
      n_checks++;
      if (obs !== {32'hDEAD_BEEF, 32'h2000_0004, 4'b1111, 1'b1, 2'b10, 1'b0})
        $display("FAIL wait_hold[%0d]: got %h expected data=DEADBEEF addr=20000004 mask=1111 htrans=10", i, obs);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h3000_0008, 32'hCAFE_BABE);
    tick();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 32'h4000_0000, 32'h1111_1111);
    tick();
    n_checks++;
    if (obs !== 72'h0)
      $display("FAIL reset_in_wait: got %h expected all zero", obs);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0001, 32'h0000_0077);
    tick();
    n_checks++;
    if (obs !== {32'h0000_7700, 32'h0000_0000, 4'b0010, 1'b1, 2'b10, 1'b0})
      $display("FAIL first_after_reset: got %h expected data=00007700 mask=0010", obs);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'b10, 32'(i * 4), $urandom);
      tick();
      n_checks++;
      if (dmreq !== 1'b1 || htrans !== 2'b10)
        $display("FAIL back_to_back[%0d]: got req=%b htrans=%b expected req=1 htrans=10", i, dmreq, htrans);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
            1'($urandom), 2'($urandom), $urandom, $urandom);
      tick();
      n_checks++;
      if (obs !== exp_b)
        $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_b);
      else n_pass++;
    end
  endtask

  initial begin
    exp_b = '0;
    drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
    test_reset();
    test_directed();
    test_wait_state();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msrv32_store_unit.md
MSRV32_STORE_UNIT -- requirements
Module: msrv32_store_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide ms_riscv32_mp_clk_in  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL provide ms_riscv32_mp_rst_in  input  1  synchronous active-high reset.
REQ-004 SHALL provide funct3_in  input  2  store size: 00 SB, 01 SH, 10 SW, 11 treated as SW.
REQ-005 SHALL provide iadder_in  input  32  effective byte address from the immediate adder.
REQ-006 SHALL provide rs2_in  input  32  store data source register.
REQ-007 SHALL provide ahb_ready_in  input  1  bus ready (HREADY); 0 inserts a wait state.
REQ-008 SHALL provide mem_wr_req_in  input  1  store request from the decoder.
REQ-009 SHALL provide ms_riscv32_mp_dmdata_out  output  32  lane-aligned write data.
REQ-010 SHALL provide ms_riscv32_mp_dmaddr_out  output  32  word-aligned write address.
REQ-011 SHALL provide ms_riscv32_mp_dmwr_mask_out  output  4  byte-lane write enables; bit n enables data[8n+7:8n].
REQ-012 SHALL provide ms_riscv32_mp_dmwr_req_out  output  1  write request.
REQ-013 SHALL provide ahb_htrans_out  output  2  AHB HTRANS: 2'b00 IDLE, 2'b10 NONSEQ.

Function
REQ-014 SHALL register all outputs; the outputs reflect the inputs sampled at the previous rising edge on which ahb_ready_in=1, giving a latency of 1 cycle.
REQ-015 SHALL hold every output unchanged on any edge where ahb_ready_in=0 (wait state), even if inputs change.
REQ-016 SHALL compute the address as {iadder_in[31:2],2'b00}.
REQ-017 SB SHALL produce data = rs2_in[7:0] shifted left by 8*iadder_in[1:0], other bytes 0, and mask = 4'b0001 << iadder_in[1:0].
REQ-018 SH SHALL produce data {16'h0,rs2_in[15:0]} with mask 4'b0011 when iadder_in[1]=0, and {rs2_in[15:0],16'h0} with mask 4'b1100 when iadder_in[1]=1; iadder_in[0] is ignored.
REQ-019 SW and funct3_in=11 SHALL produce data = rs2_in and mask = 4'b1111, ignoring iadder_in[1:0].
REQ-020 With mem_wr_req_in=0 at a capturing edge, the block SHALL register mask=4'b0000, dmwr_req=0, htrans=IDLE; data and address are still updated per REQ-016..019.
REQ-021 With mem_wr_req_in=1 at a capturing edge, the block SHALL register dmwr_req=1 and htrans=2'b10; back-to-back requests produce NONSEQ on consecutive cycles with no IDLE gap.
REQ-022 The unit SHALL have no internal state other than the output registers; no FSM.

Reset
REQ-023 Reset SHALL have priority over ahb_ready_in; on an edge with rst=1 all outputs SHALL become 0 (data 0, address 0, mask 0000, dmwr_req 0, htrans 00).
REQ-024 Reset asserted mid-transfer, including during a wait state, SHALL abort the transfer; the first capture after reset release follows REQ-014.

Configuration
REQ-025 Macro STORE_MISALIGN_CHECK_EN: when defined, the block SHALL add output misaligned_store_out (1 bit, registered, reset 0); SH with iadder_in[0]=1 and SW with iadder_in[1:0]!=00 SHALL set it to 1 and force mask=0000, dmwr_req=0 and htrans=IDLE for that capture.
REQ-026 Without STORE_MISALIGN_CHECK_EN, the port SHALL be absent and misaligned stores SHALL be issued per REQ-017..019 with offset bits dropped.

Verification
REQ-027 Reset, then SH with iadder=32'h12345672, rs2=32'hABCDEF01, ready=1, req=1 -> after 1 edge: data 32'hEF010000, addr 32'h12345670, mask 1100, dmwr_req 1, htrans 10.
REQ-028 SB with iadder=32'h00000103, rs2=32'h000000A5 -> data 32'hA5000000, addr 32'h00000100, mask 1000.
REQ-029 SW with iadder=32'h20000004, rs2=32'hDEADBEEF, then ready=0 for 3 cycles while the inputs change -> outputs hold 32'hDEADBEEF, 32'h20000004, mask 1111, htrans 10.
REQ-030 Request with req=0, ready=1 -> mask 0000, dmwr_req 0, htrans 00.
REQ-031 Assert rst during a ready=0 wait state -> all outputs 0 on that edge.
REQ-032 With STORE_MISALIGN_CHECK_EN, SW at iadder=32'h00000002 -> misaligned_store_out 1, mask 0000, htrans 00.
